sap_control_sequencer: RTL and testbench

- Microcode sequencer for the 8-bit accumulator machine built around the add/sub ALU.
- Steps through fetch/execute T-states and decodes the IR opcode into per-cycle control lines: bus drivers/loads, ALU sub select, flag latch, halt.
- Holds the carry/zero flag register fed by the ALU's Cout/ZERO outputs.
- Sits between the instruction register and the datapath; owns no data bus itself.

---
 rtl/sap_control_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_sap_control_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// Microcode sequencer and carry/zero flag register for the 8-bit SAP accumulator machine.
// Optional jump opcodes (JMP/JC/JZ) are enabled by defining SAP_JUMP_EN.
module sap_control_sequencer #(
    parameter bit AUTO_RUN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       alu_cout,
    input  logic       alu_zero,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ram_in,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_in,
    output logic       out_in,
    output logic       halt,
    output logic       carry_flag,
    output logic       zero_flag,
    output logic [2:0] tstate
);

    // state  | meaning
    // IDLE   | stopped, waiting for run (or AUTO_RUN)
    // T0     | fetch 1: PC -> MAR
    // T1     | fetch 2: RAM -> IR, PC++
    // T2..T4 | execute steps, length depends on opcode
    // HALT   | HLT executed, held until reset
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;
`ifdef SAP_JUMP_EN
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    logic pc_load_c;
`endif

    state_t state, state_nxt;
    logic   instr_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        instr_end = 1'b0;
        pc_out    = 1'b0;
        pc_inc    = 1'b0;
        mar_in    = 1'b0;
        ram_out   = 1'b0;
        ram_in    = 1'b0;
        ir_in     = 1'b0;
        ir_out    = 1'b0;
        a_in      = 1'b0;
        a_out     = 1'b0;
        b_in      = 1'b0;
        alu_out   = 1'b0;
        alu_sub   = 1'b0;
        flags_in  = 1'b0;
        out_in    = 1'b0;
        halt      = 1'b0;
`ifdef SAP_JUMP_EN
        pc_load_c = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (run || AUTO_RUN) state_nxt = S_T0;
            end
            S_T0: begin
                pc_out    = 1'b1;
                mar_in    = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                ram_out   = 1'b1;
                ir_in     = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = S_T2;
            end
            S_T2: begin
                state_nxt = S_T3;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ir_out = 1'b1;
                        mar_in = 1'b1;
                    end
                    OP_LDI: begin
                        ir_out    = 1'b1;
                        a_in      = 1'b1;
                        instr_end = 1'b1;
                    end
                    OP_OUT: begin
                        a_out     = 1'b1;
                        out_in    = 1'b1;
                        instr_end = 1'b1;
                    end
                    OP_HLT: state_nxt = S_HALT;
`ifdef SAP_JUMP_EN
                    // flags were latched before T2, so the branch decision is stable here
                    OP_JMP, OP_JC, OP_JZ: begin
                        if ((opcode == OP_JMP) ||
                            (opcode == OP_JC && carry_flag) ||
                            (opcode == OP_JZ && zero_flag)) begin
                            ir_out    = 1'b1;
                            pc_load_c = 1'b1;
                        end
                        instr_end = 1'b1;
                    end
`endif
                    default: instr_end = 1'b1;
                endcase
            end
            S_T3: begin
                state_nxt = S_T4;
                case (opcode)
                    OP_LDA: begin
                        ram_out   = 1'b1;
                        a_in      = 1'b1;
                        instr_end = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ram_out = 1'b1;
                        b_in    = 1'b1;
                    end
                    OP_STA: begin
                        a_out     = 1'b1;
                        ram_in    = 1'b1;
                        instr_end = 1'b1;
                    end
                    default: instr_end = 1'b1;
                endcase
            end
            S_T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    alu_out  = 1'b1;
                    a_in     = 1'b1;
                    flags_in = 1'b1;
                    alu_sub  = (opcode == OP_SUB);
                end
                instr_end = 1'b1;
            end
            S_HALT: halt = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
        // run is only honoured at instruction boundaries
        if (instr_end) state_nxt = run ? S_T0 : S_IDLE;
    end

`ifdef SAP_JUMP_EN
    assign pc_load = pc_load_c;
`else
    assign pc_load = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else if (flags_in) begin
            carry_flag <= alu_cout;
            zero_flag  <= alu_zero;
        end
    end

    assign tstate = state;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed testbench for sap_control_sequencer: walks each opcode's microcode and checks
// per-cycle control lines, state code, flags, halt and the single-bus-driver rule.
module tb_sap_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic       alu_cout;
    logic       alu_zero;
    logic       pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic       a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt;
    logic       carry_flag, zero_flag;
    logic [2:0] tstate;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [15:0] PC_OUT   = 16'h8000;
    localparam logic [15:0] PC_INC   = 16'h4000;
    localparam logic [15:0] PC_LOAD  = 16'h2000;
    localparam logic [15:0] MAR_IN   = 16'h1000;
    localparam logic [15:0] RAM_OUT  = 16'h0800;
    localparam logic [15:0] RAM_IN   = 16'h0400;
    localparam logic [15:0] IR_IN    = 16'h0200;
    localparam logic [15:0] IR_OUT   = 16'h0100;
    localparam logic [15:0] A_IN     = 16'h0080;
    localparam logic [15:0] A_OUT    = 16'h0040;
    localparam logic [15:0] B_IN     = 16'h0020;
    localparam logic [15:0] ALU_OUT  = 16'h0010;
    localparam logic [15:0] ALU_SUB  = 16'h0008;
    localparam logic [15:0] FLAGS_IN = 16'h0004;
    localparam logic [15:0] OUT_IN   = 16'h0002;
    localparam logic [15:0] HALT     = 16'h0001;

    logic [15:0] ctrl;
    assign ctrl = {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
                   a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt};

    sap_control_sequencer #(.AUTO_RUN(1'b0)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .alu_cout(alu_cout), .alu_zero(alu_zero),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load),
        .mar_in(mar_in), .ram_out(ram_out), .ram_in(ram_in),
        .ir_in(ir_in), .ir_out(ir_out),
        .a_in(a_in), .a_out(a_out), .b_in(b_in),
        .alu_out(alu_out), .alu_sub(alu_sub), .flags_in(flags_in),
        .out_in(out_in), .halt(halt),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .tstate(tstate)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // check state code, control word and bus exclusivity for the current cycle, then advance
    task automatic step(input string tag, input logic [2:0] exp_t, input logic [15:0] exp_c);
        int drivers;
        drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
        check({tag, ".tstate"}, 32'(tstate), 32'(exp_t));
        check({tag, ".ctrl"}, 32'(ctrl), 32'(exp_c));
        check({tag, ".bus1"}, 32'(drivers <= 1), 32'd1);
        tick();
    endtask

    task automatic fetch(input string tag);
        step({tag, ".T0"}, 3'd1, PC_OUT | MAR_IN);
        step({tag, ".T1"}, 3'd2, RAM_OUT | IR_IN | PC_INC);
    endtask

    initial begin
        rst      = 1'b1;
        run      = 1'b0;
        opcode   = 4'h0;
        alu_cout = 1'b0;
        alu_zero = 1'b0;
        tick();
        tick();
        check("rst.tstate", 32'(tstate), 32'd0);
        check("rst.ctrl", 32'(ctrl), 32'd0);
        check("rst.flags", {30'd0, carry_flag, zero_flag}, 32'd0);
        rst = 1'b0;
        step("idle_wait", 3'd0, 16'h0);
        step("idle_wait2", 3'd0, 16'h0);

        // LDI
        run = 1'b1;
        opcode = 4'h5;
        step("ldi.idle", 3'd0, 16'h0);
        fetch("ldi");
        step("ldi.T2", 3'd3, IR_OUT | A_IN);

        // ADD, flags set to 1/1
        opcode = 4'h1;
        fetch("add");
        step("add.T2", 3'd3, IR_OUT | MAR_IN);
        step("add.T3", 3'd4, RAM_OUT | B_IN);
        alu_cout = 1'b1;
        alu_zero = 1'b1;
        check("add.flags_pre", {30'd0, carry_flag, zero_flag}, 32'd0);
        step("add.T4", 3'd5, ALU_OUT | A_IN | FLAGS_IN);
        check("add.flags", {30'd0, carry_flag, zero_flag}, 32'd3);

        // SUB, flags cleared by borrow=0/zero=0
        opcode = 4'h2;
        alu_cout = 1'b0;
        alu_zero = 1'b0;
        fetch("sub");
        step("sub.T2", 3'd3, IR_OUT | MAR_IN);
        check("sub.flags_hold", {30'd0, carry_flag, zero_flag}, 32'd3);
        step("sub.T3", 3'd4, RAM_OUT | B_IN);
        step("sub.T4", 3'd5, ALU_OUT | A_IN | FLAGS_IN | ALU_SUB);
        check("sub.flags", {30'd0, carry_flag, zero_flag}, 32'd0);

        // LDA with ALU outputs high: flags must hold
        opcode = 4'h0;
        alu_cout = 1'b1;
        alu_zero = 1'b1;
        fetch("lda");
        step("lda.T2", 3'd3, IR_OUT | MAR_IN);
        step("lda.T3", 3'd4, RAM_OUT | A_IN);
        check("lda.flags_hold", {30'd0, carry_flag, zero_flag}, 32'd0);

        opcode = 4'h4;
        fetch("sta");
        step("sta.T2", 3'd3, IR_OUT | MAR_IN);
        step("sta.T3", 3'd4, A_OUT | RAM_IN);

        opcode = 4'hE;
        fetch("out");
        step("out.T2", 3'd3, A_OUT | OUT_IN);

        opcode = 4'h3;
        fetch("nop3");
        step("nop3.T2", 3'd3, 16'h0);

        // JC with carry=0, JZ with zero=0: never taken
        opcode = 4'h7;
        fetch("jc0");
        step("jc0.T2", 3'd3, 16'h0);
        opcode = 4'h8;
        fetch("jz0");
        step("jz0.T2", 3'd3, 16'h0);

        // ADD sets carry=1, zero=0
        opcode = 4'h1;
        alu_cout = 1'b1;
        alu_zero = 1'b0;
        fetch("add2");
        step("add2.T2", 3'd3, IR_OUT | MAR_IN);
        step("add2.T3", 3'd4, RAM_OUT | B_IN);
        step("add2.T4", 3'd5, ALU_OUT | A_IN | FLAGS_IN);
        check("add2.flags", {30'd0, carry_flag, zero_flag}, 32'd2);

        opcode = 4'h7;
        fetch("jc1");
`ifdef SAP_JUMP_EN
        step("jc1.T2", 3'd3, IR_OUT | PC_LOAD);
`else
        step("jc1.T2", 3'd3, 16'h0);
`endif
        opcode = 4'h8;
        fetch("jz_nz");
        step("jz_nz.T2", 3'd3, 16'h0);
        opcode = 4'h6;
        fetch("jmp");
`ifdef SAP_JUMP_EN
        step("jmp.T2", 3'd3, IR_OUT | PC_LOAD);
`else
        step("jmp.T2", 3'd3, 16'h0);
`endif

        // run dropped mid-ADD: finishes T4 then idles
        opcode = 4'h1;
        alu_cout = 1'b1;
        alu_zero = 1'b1;
        fetch("drop");
        step("drop.T2", 3'd3, IR_OUT | MAR_IN);
        run = 1'b0;
        step("drop.T3", 3'd4, RAM_OUT | B_IN);
        step("drop.T4", 3'd5, ALU_OUT | A_IN | FLAGS_IN);
        step("drop.idle1", 3'd0, 16'h0);
        step("drop.idle2", 3'd0, 16'h0);
        run = 1'b1;
        opcode = 4'hF;
        step("resume.idle", 3'd0, 16'h0);
        fetch("hlt");
        step("hlt.T2", 3'd3, 16'h0);
        for (int i = 0; i < 10; i++) begin
            run = i[0];
            step("halt.hold", 3'd6, HALT);
        end
        check("halt.flags", {30'd0, carry_flag, zero_flag}, 32'd3);

        // asynchronous reset, sampled before any clock edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst.tstate", 32'(tstate), 32'd0);
        check("arst.ctrl", 32'(ctrl), 32'd0);
        check("arst.flags", {30'd0, carry_flag, zero_flag}, 32'd0);
        tick();
        rst = 1'b0;
        run = 1'b0;
        step("post.idle", 3'd0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
